// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - scanned 7-segment receiver recovering 4-digit hour/minute frames
module seg_scan_decoder #(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [6:0]  segment,
   input  logic [3:0]  digit_sel,
   output logic [15:0] digits,
   output logic [3:0]  blank_mask,
   output logic [4:0]  hour,
   output logic [5:0]  minute,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        code_err,
   output logic        link_lost
);

   localparam logic [3:0]  STABLE_N     = 4'(STABLE_CYCLES);
   localparam logic [19:0] TIMEOUT_N    = 20'(TIMEOUT_CYCLES);
   localparam logic [19:0] TIMEOUT_N_M1 = 20'(TIMEOUT_CYCLES - 1);

   // input sampling and stability tracking
   logic [6:0]  seg_in_q, seg_in_d;
   logic [3:0]  sel_in_q, sel_in_d;
   logic [10:0] prev_q, prev_d;
   logic [3:0]  stab_q, stab_d;
   logic [19:0] tmo_q, tmo_d;

   // frame staging
   logic [15:0] stage_q, stage_d;
   logic [3:0]  mask_q, mask_d;
   logic [3:0]  bad_q, bad_d;

   // registered outputs
   logic [15:0] digits_q, digits_d;
   logic [3:0]  blank_mask_q, blank_mask_d;
   logic [4:0]  hour_q, hour_d;
   logic [5:0]  minute_q, minute_d;
   logic        frame_valid_q, frame_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        code_err_q, code_err_d;
   logic        link_lost_q, link_lost_d;

   // combinational helpers
   logic        onehot_c;
   logic        changed_c;
   logic        capture_c;
   logic [3:0]  dec_val_c;
   logic        dec_bad_c;
   logic        complete_c;
   logic        tmo_hit_c;
   logic [3:0]  val_c [4];
   logic [3:0]  blank_c;
   logic [6:0]  hour_full_c;
   logic [6:0]  minute_full_c;
   logic        accept_c;
   logic        reject_c;

   // classify the registered digit select and decide when a dwell is stable enough to capture
   always_comb begin
      onehot_c = 1'b0;
      case (sel_in_q)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: onehot_c = 1'b1;
         default:                            onehot_c = 1'b0;
      endcase
      changed_c = ({sel_in_q, seg_in_q} != prev_q);
      if (!onehot_c) begin
         stab_d = 4'd0;
      end else if (changed_c || stab_q == 4'd0) begin
         stab_d = 4'd1;
      end else if (stab_q < STABLE_N) begin
         stab_d = stab_q + 4'd1;
      end else begin
         stab_d = stab_q;
      end
      // the counter holds at the threshold, so a long dwell only matches once
      capture_c = onehot_c && (stab_d == STABLE_N) && (changed_c || stab_q != STABLE_N);
   end

   // segment pattern to BCD; 4'hF stands for blank and for undecodable patterns
   always_comb begin
      dec_val_c = 4'hF;
      dec_bad_c = 1'b0;
      case (seg_in_q)
         7'h3F:   dec_val_c = 4'd0;
         7'h06:   dec_val_c = 4'd1;
         7'h5B:   dec_val_c = 4'd2;
         7'h4F:   dec_val_c = 4'd3;
         7'h66:   dec_val_c = 4'd4;
         7'h6D:   dec_val_c = 4'd5;
         7'h7D:   dec_val_c = 4'd6;
         7'h07:   dec_val_c = 4'd7;
         7'h7F:   dec_val_c = 4'd8;
         7'h6F:   dec_val_c = 4'd9;
         7'h00:   dec_val_c = 4'hF;
         default: dec_bad_c = 1'b1;
      endcase
   end

   // evaluate a completed frame: blanks count as zero, x10 done as (x<<3)+(x<<1)
   always_comb begin
      complete_c = (mask_q == 4'hF);
      for (int i = 0; i < 4; i++) begin
         blank_c[i] = (stage_q[i*4 +: 4] == 4'hF);
         val_c[i]   = blank_c[i] ? 4'd0 : stage_q[i*4 +: 4];
      end
      hour_full_c   = {val_c[3], 3'b000} + {2'b00, val_c[3], 1'b0} + {3'b000, val_c[2]};
      minute_full_c = {val_c[1], 3'b000} + {2'b00, val_c[1], 1'b0} + {3'b000, val_c[0]};
      accept_c = complete_c && (bad_q == 4'h0) && (hour_full_c <= 7'd23) && (minute_full_c <= 7'd59);
      reject_c = complete_c && !accept_c;
   end

   // next-state for staging, link timeout and outputs
   always_comb begin
      seg_in_d = segment;
      sel_in_d = digit_sel;
      prev_d   = {sel_in_q, seg_in_q};

      // a capture restarts the silence timer; otherwise count up and stick at the limit
      tmo_hit_c = !capture_c && (tmo_q == TIMEOUT_N_M1);
      if (capture_c) begin
         tmo_d = 20'd0;
      end else if (tmo_q != TIMEOUT_N) begin
         tmo_d = tmo_q + 20'd1;
      end else begin
         tmo_d = tmo_q;
      end

      // a completed or timed-out frame empties the staging area before this cycle's capture lands
      stage_d = stage_q;
      mask_d  = complete_c ? 4'h0 : mask_q;
      bad_d   = complete_c ? 4'h0 : bad_q;
      if (tmo_hit_c) begin
         mask_d = 4'h0;
         bad_d  = 4'h0;
      end
      if (capture_c) begin
         mask_d = mask_d | sel_in_q;
         bad_d  = (bad_d & ~sel_in_q) | (dec_bad_c ? sel_in_q : 4'h0);
         for (int i = 0; i < 4; i++) begin
            if (sel_in_q[i]) begin
               stage_d[i*4 +: 4] = dec_val_c;
            end
         end
      end

      digits_d      = digits_q;
      blank_mask_d  = blank_mask_q;
      hour_d        = hour_q;
      minute_d      = minute_q;
      frame_valid_d = accept_c;
      frame_err_d   = reject_c;
      code_err_d    = capture_c && dec_bad_c;
      link_lost_d   = link_lost_q;
      if (tmo_hit_c) begin
         link_lost_d = 1'b1;
      end
      if (accept_c) begin
         digits_d     = stage_q;
         blank_mask_d = blank_c;
         hour_d       = hour_full_c[4:0];
         minute_d     = minute_full_c[5:0];
         link_lost_d  = 1'b0;
      end
   end

   // state registers with asynchronous active-low reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg_in_q      <= 7'h00;
         sel_in_q      <= 4'h0;
         prev_q        <= 11'h000;
         stab_q        <= 4'd0;
         tmo_q         <= 20'd0;
         stage_q       <= 16'hFFFF;
         mask_q        <= 4'h0;
         bad_q         <= 4'h0;
         digits_q      <= 16'hFFFF;
         blank_mask_q  <= 4'hF;
         hour_q        <= 5'd0;
         minute_q      <= 6'd0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         code_err_q    <= 1'b0;
         link_lost_q   <= 1'b1;
      end else begin
         seg_in_q      <= seg_in_d;
         sel_in_q      <= sel_in_d;
         prev_q        <= prev_d;
         stab_q        <= stab_d;
         tmo_q         <= tmo_d;
         stage_q       <= stage_d;
         mask_q        <= mask_d;
         bad_q         <= bad_d;
         digits_q      <= digits_d;
         blank_mask_q  <= blank_mask_d;
         hour_q        <= hour_d;
         minute_q      <= minute_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         code_err_q    <= code_err_d;
         link_lost_q   <= link_lost_d;
      end
   end

   assign digits      = digits_q;
   assign blank_mask  = blank_mask_q;
   assign hour        = hour_q;
   assign minute      = minute_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign code_err    = code_err_q;
   assign link_lost   = link_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
module tb_seg_scan_decoder;

   localparam int STABLE = 4;
   localparam int TMO    = 300;

   logic        clock = 1'b0;
   logic        reset;
   logic [6:0]  segment;
   logic [3:0]  digit_sel;
   logic [15:0] digits;
   logic [3:0]  blank_mask;
   logic [4:0]  hour;
   logic [5:0]  minute;
   logic        frame_valid;
   logic        frame_err;
   logic        code_err;
   logic        link_lost;

   seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset(reset), .segment(segment), .digit_sel(digit_sel),
      .digits(digits), .blank_mask(blank_mask), .hour(hour), .minute(minute),
      .frame_valid(frame_valid), .frame_err(frame_err), .code_err(code_err),
      .link_lost(link_lost)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        ok;
      logic [15:0] dig;
      logic [3:0]  blk;
      logic [4:0]  hr;
      logic [5:0]  mn;
   } exp_t;

   exp_t exp_q[$];
   int   code_q[$];
   int   total = 0;
   int   bad   = 0;

   logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   logic [6:0]  pat [4];
   logic [15:0] m_dig;
   logic [3:0]  m_blk;
   logic [4:0]  m_hour;
   logic [5:0]  m_min;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // 0..9 digit value, 15 blank, -1 undecodable
   function automatic int decode(input logic [6:0] p);
      if (p == 7'h00) return 15;
      for (int k = 0; k < 10; k++) if (seg_tab[k] == p) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_dig = 16'hFFFF; m_blk = 4'hF; m_hour = 5'd0; m_min = 6'd0;
   endtask

   // reference: evaluate the frame in pat[] from the display rules and queue the response
   task automatic model_push();
      int   v [4];
      int   num [4];
      int   hv, mv;
      logic anybad;
      exp_t e;
      logic [15:0] nd;
      logic [3:0]  nb;
      anybad = 1'b0;
      nd = 16'h0;
      nb = 4'h0;
      for (int i = 3; i >= 0; i--) begin
         v[i] = decode(pat[i]);
         if (v[i] < 0) begin
            anybad = 1'b1;
            code_q.push_back(i);
         end
      end
      for (int i = 0; i < 4; i++) begin
         num[i] = (v[i] < 0 || v[i] == 15) ? 0 : v[i];
         nd[i*4 +: 4] = (v[i] < 0) ? 4'hF : 4'(v[i]);
         nb[i] = (v[i] == 15);
      end
      hv = 10 * num[3] + num[2];
      mv = 10 * num[1] + num[0];
      e.ok = !anybad && hv <= 23 && mv <= 59;
      if (e.ok) begin
         m_dig = nd; m_blk = nb; m_hour = 5'(hv); m_min = 6'(mv);
      end
      e.dig = m_dig; e.blk = m_blk; e.hr = m_hour; e.mn = m_min;
      exp_q.push_back(e);
   endtask

   task automatic drive_digit(input int idx, input logic [6:0] p, input int dwell, input int gap);
      for (int c = 0; c < dwell; c++) begin
         @(negedge clock);
         digit_sel = 4'(1 << idx);
         segment   = p;
      end
      for (int c = 0; c < gap; c++) begin
         @(negedge clock);
         digit_sel = 4'h0;
         segment   = 7'h00;
      end
   endtask

   task automatic scan_frame(input int dwell, input int gap);
      model_push();
      for (int i = 3; i >= 0; i--) drive_digit(i, pat[i], dwell, gap);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         digit_sel = 4'h0;
         segment   = 7'h00;
      end
   endtask

   task automatic set_pat(input logic [6:0] p3, input logic [6:0] p2, input logic [6:0] p1, input logic [6:0] p0);
      pat[3] = p3; pat[2] = p2; pat[1] = p1; pat[0] = p0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_digits"}, digits, 16'hFFFF);
      check({tag, "_blank"}, blank_mask, 4'hF);
      check({tag, "_hour"}, hour, 0);
      check({tag, "_minute"}, minute, 0);
      check({tag, "_pulses"}, {frame_valid, frame_err, code_err}, 0);
      check({tag, "_link_lost"}, link_lost, 1);
   endtask

   // monitor: pop and compare whenever the DUT reports a frame or a code error
   always @(negedge clock) begin
      exp_t e;
      if (frame_valid || frame_err) begin
         check("pulse_exclusive", {31'b0, frame_valid & frame_err}, 0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: valid=%0b err=%0b digits=%0h with nothing expected", frame_valid, frame_err, digits);
         end else begin
            e = exp_q.pop_front();
            check("frame_accept", frame_valid, e.ok);
            check("frame_digits", digits, e.dig);
            check("frame_blank", blank_mask, e.blk);
            check("frame_hour", hour, e.hr);
            check("frame_minute", minute, e.mn);
            if (e.ok) check("link_lost_fall", link_lost, 0);
         end
      end
      if (code_err) begin
         check("code_err_expected", code_q.size() > 0, 1);
         if (code_q.size() > 0) void'(code_q.pop_front());
      end
   end

   initial begin
      int r, v, dw, gp;
      logic [6:0] p;
      model_reset();
      reset = 1'b0; segment = 7'h00; digit_sel = 4'h0;
      repeat (3) @(negedge clock);
      check_reset_values("reset");
      reset = 1'b1;
      idle(2);

      // 12:34
      set_pat(7'h06, 7'h5B, 7'h4F, 7'h66);
      scan_frame(8, 2);
      idle(4);
      check("link_lost_after_first", link_lost, 0);
      // blank hour tens: F2:34
      set_pat(7'h00, 7'h5B, 7'h4F, 7'h66);
      scan_frame(8, 2);
      // 25:34 rejected, outputs hold
      set_pat(7'h5B, 7'h6D, 7'h4F, 7'h66);
      scan_frame(8, 2);
      // undecodable minute tens, long dwell must flag only once
      set_pat(7'h06, 7'h5B, 7'h49, 7'h66);
      model_push();
      drive_digit(3, pat[3], 8, 2);
      drive_digit(2, pat[2], 8, 2);
      drive_digit(1, pat[1], 20, 2);
      drive_digit(0, pat[0], 8, 2);
      idle(4);

      // glitched short dwell on minute ones must not capture '8'; clean '4' follows
      set_pat(7'h3F, 7'h6F, 7'h6D, 7'h66);
      model_push();
      drive_digit(3, pat[3], 8, 2);
      drive_digit(2, pat[2], 8, 2);
      drive_digit(1, pat[1], 8, 2);
      drive_digit(0, 7'h7F, STABLE - 2, 0);
      drive_digit(0, 7'h6F, 1, 0);
      drive_digit(0, 7'h7F, STABLE - 1, 2);
      drive_digit(0, pat[0], 8, 2);
      idle(4);

      // randomized frames
      for (int f = 0; f < 24; f++) begin
         for (int i = 0; i < 4; i++) begin
            r = $urandom_range(0, 19);
            if (r < 14) begin
               v = (i == 3) ? $urandom_range(0, 2) : (i == 1) ? $urandom_range(0, 5) : $urandom_range(0, 9);
               pat[i] = seg_tab[v];
            end else if (r < 17) begin
               pat[i] = seg_tab[$urandom_range(0, 9)];
            end else if (r < 19) begin
               pat[i] = 7'h00;
            end else begin
               p = 7'(($urandom_range(1, 127)));
               while (decode(p) != -1) p = 7'($urandom_range(1, 127));
               pat[i] = p;
            end
         end
         dw = $urandom_range(STABLE, 10);
         gp = $urandom_range(1, 3);
         scan_frame(dw, gp);
      end
      idle(6);

      // link timeout after a partial frame clears staging
      set_pat(7'h06, 7'h6D, 7'h4F, 7'h7D);
      drive_digit(3, pat[3], 8, 2);
      drive_digit(2, pat[2], 8, 2);
      idle(TMO + 50);
      check("link_lost_timeout", link_lost, 1);
      drive_digit(1, pat[1], 8, 2);
      drive_digit(0, pat[0], 8, 2);
      idle(20);
      check("link_lost_partial_hold", link_lost, 1);
      idle(TMO + 50);
      set_pat(7'h5B, 7'h4F, 7'h6D, 7'h6F);
      scan_frame(8, 2);
      idle(4);
      check("link_restored", link_lost, 0);

      // asynchronous reset in the middle of a frame
      set_pat(7'h06, 7'h07, 7'h6D, 7'h3F);
      drive_digit(3, pat[3], 8, 2);
      drive_digit(2, pat[2], 8, 2);
      drive_digit(1, pat[1], 3, 0);
      #2 reset = 1'b0;
      #1 check_reset_values("midreset");
      model_reset();
      @(negedge clock);
      digit_sel = 4'h0; segment = 7'h00;
      reset = 1'b1;
      idle(2);
      scan_frame(8, 2);
      idle(20);

      check("frames_drained", exp_q.size(), 0);
      check("code_errs_drained", code_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
